// File: rtl/rip_instruction_fetch.sv
// rip_instruction_fetch: PC owner and 1-cycle-latency fetch stage with stall hold register and zero-bubble redirect.
module rip_instruction_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    output logic                  if_ready,
    output logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] if_dout,
    output logic                  id_valid,
    output logic [DATA_WIDTH-1:0] id_inst,
    output logic [DATA_WIDTH-1:0] id_pc,
    output logic                  id_misaligned
);
    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(4);

    logic [DATA_WIDTH-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
    logic [DATA_WIDTH-1:0] hold_inst_q, hold_inst_d, hold_pc_q, hold_pc_d;
    logic                  inflight_q, inflight_d, hold_valid_q, hold_valid_d;

    // Reset gating keeps every output at its reset value while rstn is low,
    // even though if_dout and redirect inputs may be toggling.
    assign pc            = (rstn & redirect_valid) ? redirect_target : pc_q;
    assign if_ready      = rstn & (redirect_valid | ~stall);
    assign id_valid      = rstn & ~redirect_valid & (hold_valid_q | inflight_q);
    assign id_inst       = ~rstn ? '0 : hold_valid_q ? hold_inst_q : if_dout;
    assign id_pc         = hold_valid_q ? hold_pc_q : inflight_pc_q;
    assign id_misaligned = id_valid & (id_pc[1:0] != 2'b00);

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        hold_valid_d  = hold_valid_q;
        hold_inst_d   = hold_inst_q;
        hold_pc_d     = hold_pc_q;
        if (redirect_valid) begin
            pc_d          = redirect_target + STEP;
            inflight_d    = 1'b1;
            inflight_pc_d = redirect_target;
            hold_valid_d  = 1'b0;
        end else if (!stall) begin
            pc_d          = pc_q + STEP;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            hold_valid_d  = 1'b0;
        end else if (inflight_q && !hold_valid_q) begin
            // Memory data is only valid for one cycle, so park it before it vanishes.
            hold_inst_d  = if_dout;
            hold_pc_d    = inflight_pc_q;
            hold_valid_d = 1'b1;
            inflight_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q          <= RESET_VECTOR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            hold_valid_q  <= 1'b0;
            hold_inst_q   <= '0;
            hold_pc_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            hold_valid_q  <= hold_valid_d;
            hold_inst_q   <= hold_inst_d;
            hold_pc_q     <= hold_pc_d;
        end
    end
endmodule
